// File: rtl/otter_mem_ctrl.sv
// ---------------------------------------------------------------------------
// OtterMemCtrl -- load/store controller between the OTTER core and a simple
// word-wide handshake bus.
//
// It accepts one load or store from the decoder, checks alignment and size,
// drives a single bus cycle with byte enables and lane-replicated write data,
// and returns a sign- or zero-extended load result. The core is stalled while
// a bus cycle is outstanding.
//
// Ports
//   CLK           in   1   clock, rising edge
//   RST_N         in   1   synchronous active-low reset
//   MEM_READ2     in   1   load request
//   MEM_WRITE     in   1   store request (wins over a simultaneous load)
//   MEM_SIZE      in   2   00 byte, 01 half, 10 word, 11 illegal
//   MEM_UNSIGNED  in   1   zero-extend loads
//   ADDR          in  32   byte address
//   WDATA         in  32   store data
//   STALL         out  1   holds the core's PC/IR
//   RDATA         out 32   extended load result, held until the next load
//   RDATA_VALID   out  1   one-cycle pulse in DONE for a completed load
//   ERR           out  1   one-cycle misaligned / illegal-size (or timeout) pulse
//   BUS_REQ       out  1   high exactly while waiting for the bus
//   BUS_WE        out  1   bus write enable
//   BUS_ADDR      out 32   word address, bits [1:0] = 00
//   BUS_BE        out  4   byte enables
//   BUS_WDATA     out 32   lane-replicated store data
//   BUS_ACK       in   1   bus completion pulse
//   BUS_RDATA     in  32   bus read data, valid with BUS_ACK
//
// Build option
//   OTTER_MEM_TIMEOUT_EN  when defined, a bus cycle that sees no BUS_ACK for
//                         255 WAIT cycles is abandoned with an ERR pulse.
// ---------------------------------------------------------------------------
module otter_mem_ctrl (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MEM_READ2,
  input  logic        MEM_WRITE,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_UNSIGNED,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        STALL,
  output logic [31:0] RDATA,
  output logic        RDATA_VALID,
  output logic        ERR,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_BE,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_RDATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;

  logic        req_ok;
  logic        accept;
  logic        reject;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;
  logic        timeout_hit;
  logic        timed_out;

  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic        load_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] rdata_q;

  // Request decode: alignment/size legality plus the lane pattern the bus
  // cycle would use. A half at offset 3 is misaligned, so the shifted enable
  // never runs off the top of the 4-bit field.
  always_comb begin
    req_ok     = 1'b0;
    be_next    = 4'b0000;
    wdata_next = WDATA;
    case (MEM_SIZE)
      2'b00: begin
        req_ok     = 1'b1;
        be_next    = 4'b0001 << ADDR[1:0];
        wdata_next = {4{WDATA[7:0]}};
      end
      2'b01: begin
        req_ok     = ~ADDR[0];
        be_next    = 4'b0011 << ADDR[1:0];
        wdata_next = {2{WDATA[15:0]}};
      end
      2'b10: begin
        req_ok     = (ADDR[1:0] == 2'b00);
        be_next    = 4'b1111;
        wdata_next = WDATA;
      end
      default: begin
        req_ok     = 1'b0;
      end
    endcase
    accept = RST_N && (state == IDLE) && (MEM_READ2 || MEM_WRITE) && req_ok;
    reject = RST_N && (state == IDLE) && (MEM_READ2 || MEM_WRITE) && !req_ok;
  end

  // Load extraction from the registered lane offset and size; a word load is
  // aligned, so its shift is zero and it passes straight through.
  always_comb begin
    load_shifted = BUS_RDATA >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'b0, load_shifted[7:0]}
                                     : {{24{load_shifted[7]}}, load_shifted[7:0]};
      2'b01:   load_ext = unsigned_q ? {16'b0, load_shifted[15:0]}
                                     : {{16{load_shifted[15]}}, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // Next-state logic. DONE always returns to IDLE, so the request the core is
  // still presenting during DONE is never taken a second time.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (BUS_ACK || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // Bus-cycle registers are loaded only on accept, which keeps every BUS_*
  // output frozen for the whole of WAIT. RDATA is only touched by an ACKed load.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      load_q      <= 1'b0;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      if (accept) begin
        bus_we_q    <= MEM_WRITE;
        bus_addr_q  <= {ADDR[31:2], 2'b00};
        bus_be_q    <= be_next;
        bus_wdata_q <= wdata_next;
        load_q      <= ~MEM_WRITE;
        lane_q      <= ADDR[1:0];
        size_q      <= MEM_SIZE;
        unsigned_q  <= MEM_UNSIGNED;
      end
      if ((state == WAIT) && BUS_ACK && load_q) begin
        rdata_q <= load_ext;
      end
    end
  end

`ifdef OTTER_MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       timed_out_q;

  // The counter holds 254 during the 255th WAIT cycle; without an ACK that
  // cycle abandons the bus cycle. An ACK in the same cycle still wins.
  assign timeout_hit = (state == WAIT) && !BUS_ACK && (tmo_cnt == 8'd254);
  assign timed_out   = timed_out_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tmo_cnt     <= 8'd0;
      timed_out_q <= 1'b0;
    end else if (accept) begin
      tmo_cnt     <= 8'd0;
      timed_out_q <= 1'b0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 8'd1;
      if (timeout_hit) timed_out_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  // Outputs. STALL and the alignment ERR are combinational so the core is
  // held (or trapped) in the same cycle it presents the request.
  assign STALL       = accept || (state == WAIT);
  assign ERR         = reject || ((state == DONE) && timed_out);
  assign RDATA_VALID = (state == DONE) && load_q && !timed_out;
  assign RDATA       = rdata_q;
  assign BUS_REQ     = (state == WAIT);
  assign BUS_WE      = bus_we_q;
  assign BUS_ADDR    = bus_addr_q;
  assign BUS_BE      = bus_be_q;
  assign BUS_WDATA   = bus_wdata_q;

endmodule

// File: tb/tb_otter_mem_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for otter_mem_ctrl: directed scenarios followed by randomized
// transactions, checked against an arithmetic reference model of the
// byte-lane and extension rules.
// ---------------------------------------------------------------------------
module tb_otter_mem_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        MEM_READ2;
  logic        MEM_WRITE;
  logic [1:0]  MEM_SIZE;
  logic        MEM_UNSIGNED;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic        STALL;
  logic [31:0] RDATA;
  logic        RDATA_VALID;
  logic        ERR;
  logic        BUS_REQ;
  logic        BUS_WE;
  logic [31:0] BUS_ADDR;
  logic [3:0]  BUS_BE;
  logic [31:0] BUS_WDATA;
  logic        BUS_ACK;
  logic [31:0] BUS_RDATA;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'h0;

  otter_mem_ctrl dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .MEM_READ2    (MEM_READ2),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_SIZE     (MEM_SIZE),
    .MEM_UNSIGNED (MEM_UNSIGNED),
    .ADDR         (ADDR),
    .WDATA        (WDATA),
    .STALL        (STALL),
    .RDATA        (RDATA),
    .RDATA_VALID  (RDATA_VALID),
    .ERR          (ERR),
    .BUS_REQ      (BUS_REQ),
    .BUS_WE       (BUS_WE),
    .BUS_ADDR     (BUS_ADDR),
    .BUS_BE       (BUS_BE),
    .BUS_WDATA    (BUS_WDATA),
    .BUS_ACK      (BUS_ACK),
    .BUS_RDATA    (BUS_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: access width in bytes and the rules derived from it.
  function automatic int size_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit model_ok(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'b11) return 1'b0;
    return (addr % size_bytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
    int mask;
    mask = ((1 << size_bytes(sz)) - 1) << (addr % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = size_bytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [1:0] sz, input logic uns,
                                              input logic [31:0] addr, input logic [31:0] brd);
    longint v;
    longint span;
    int n;
    n = size_bytes(sz);
    v = longint'(brd) >> (8 * (addr % 4));
    if (n < 4) begin
      span = longint'(1) << (8 * n);
      v = v % span;
      if (!uns && (v >= span / 2)) v = v - span;
    end
    return v[31:0];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drop_request();
    MEM_READ2 = 1'b0;
    MEM_WRITE = 1'b0;
  endtask

  // One complete transaction. ack_wait is the WAIT cycle (1-based) in which
  // BUS_ACK is pulsed; the request stays on the inputs through DONE, as the
  // stalled core would hold it.
  task automatic apply_stimulus(input string tag, input logic wr, input logic rd,
                                input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] brd, input int ack_wait);
    bit          ok;
    bit          is_load;
    logic [3:0]  be;
    logic [31:0] wde;
    int          stall_cnt;
    ok      = model_ok(sz, addr);
    is_load = !wr;
    @(posedge CLK); #1;
    MEM_WRITE = wr; MEM_READ2 = rd; MEM_SIZE = sz; MEM_UNSIGNED = uns;
    ADDR = addr; WDATA = wd; BUS_ACK = 1'b0;
    @(negedge CLK);
    check_output({tag, ":accept_stall"}, STALL, ok);
    check_output({tag, ":accept_err"}, ERR, !ok);
    check_output({tag, ":accept_busreq"}, BUS_REQ, 0);
    stall_cnt = (STALL === 1'b1) ? 1 : 0;
    if (!ok) begin
      @(posedge CLK); #1;
      drop_request();
      @(negedge CLK);
      check_output({tag, ":rej_busreq"}, BUS_REQ, 0);
      check_output({tag, ":rej_err_clear"}, ERR, 0);
      check_output({tag, ":rej_rdata_hold"}, RDATA, last_rdata);
      return;
    end
    be  = model_be(sz, addr);
    wde = model_wdata(sz, wd);
    for (int w = 1; w <= ack_wait; w++) begin
      @(posedge CLK); #1;
      BUS_ACK   = (w == ack_wait);
      BUS_RDATA = (w == ack_wait) ? brd : $urandom();
      @(negedge CLK);
      if (STALL === 1'b1) stall_cnt++;
      check_output({tag, ":wait_busreq"}, BUS_REQ, 1);
      check_output({tag, ":wait_we"}, BUS_WE, wr);
      check_output({tag, ":wait_addr"}, BUS_ADDR, {addr[31:2], 2'b00});
      check_output({tag, ":wait_be"}, BUS_BE, be);
      if (wr) check_output({tag, ":wait_wdata"}, BUS_WDATA, wde);
      check_output({tag, ":wait_rvalid"}, RDATA_VALID, 0);
    end
    @(posedge CLK); #1;
    BUS_ACK   = 1'b0;
    BUS_RDATA = $urandom();
    @(negedge CLK);
    if (is_load) last_rdata = model_rdata(sz, uns, addr, brd);
    check_output({tag, ":done_stall"}, STALL, 0);
    check_output({tag, ":done_busreq"}, BUS_REQ, 0);
    check_output({tag, ":done_err"}, ERR, 0);
    check_output({tag, ":done_rvalid"}, RDATA_VALID, is_load);
    check_output({tag, ":done_rdata"}, RDATA, last_rdata);
    check_output({tag, ":stall_cycles"}, stall_cnt, ack_wait + 1);
    @(posedge CLK); #1;
    drop_request();
    BUS_ACK = 1'($urandom_range(0, 1));
    @(negedge CLK);
    check_output({tag, ":idle_busreq"}, BUS_REQ, 0);
    check_output({tag, ":idle_rvalid"}, RDATA_VALID, 0);
    check_output({tag, ":idle_stall"}, STALL, 0);
    check_output({tag, ":idle_rdata"}, RDATA, last_rdata);
  endtask

  initial begin
    logic [1:0]  r_sz;
    logic [31:0] r_addr;
    int          mode;
    int          wait_cnt;

    RST_N = 1'b0; drop_request(); MEM_SIZE = 2'b00; MEM_UNSIGNED = 1'b0;
    ADDR = 32'h0; WDATA = 32'h0; BUS_ACK = 1'b0; BUS_RDATA = 32'h0;

    // Reset state.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_output("rst_stall", STALL, 0);
    check_output("rst_rdata", RDATA, 0);
    check_output("rst_rvalid", RDATA_VALID, 0);
    check_output("rst_err", ERR, 0);
    check_output("rst_busreq", BUS_REQ, 0);
    check_output("rst_we", BUS_WE, 0);
    check_output("rst_addr", BUS_ADDR, 0);
    check_output("rst_be", BUS_BE, 0);
    check_output("rst_wdata", BUS_WDATA, 0);
    RST_N = 1'b1;
    $display("[TB] reset checks complete");

    // Directed scenarios.
    apply_stimulus("byte_load", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 1);
    check_output("byte_load_value", last_rdata, 32'hFFFF_FF80);
    check_output("byte_load_be", model_be(2'b00, 32'h0000_1003), 4'b1000);
    apply_stimulus("half_store", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 1);
    apply_stimulus("word_misalign", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 1);
    apply_stimulus("ack_delay5", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'h0, 32'hDEAD_BEEF, 5);
    apply_stimulus("half_uload", 1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_6002, 32'h0, 32'h9876_0000, 2);
    apply_stimulus("both_wr_prio", 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_7001, 32'h0000_005A, 32'h0, 1);
    apply_stimulus("illegal_size", 1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_8000, 32'h0, 32'h0, 1);

    // Reset while a bus cycle is outstanding, then a late ACK.
    @(posedge CLK); #1;
    MEM_READ2 = 1'b1; MEM_SIZE = 2'b10; MEM_UNSIGNED = 1'b0; ADDR = 32'h0000_4000;
    @(negedge CLK);
    check_output("rstwait_accept", STALL, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_output("rstwait_in_wait", BUS_REQ, 1);
    @(posedge CLK); #1;
    RST_N = 1'b0; drop_request();
    @(posedge CLK); #1;
    @(negedge CLK);
    last_rdata = 32'h0;
    check_output("rstwait_busreq_drop", BUS_REQ, 0);
    check_output("rstwait_addr_clear", BUS_ADDR, 0);
    check_output("rstwait_rdata_clear", RDATA, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1; BUS_ACK = 1'b1; BUS_RDATA = 32'h1111_2222;
    @(negedge CLK);
    check_output("rstwait_late_ack_rvalid", RDATA_VALID, 0);
    check_output("rstwait_late_ack_busreq", BUS_REQ, 0);
    @(posedge CLK); #1;
    BUS_ACK = 1'b0;
    @(negedge CLK);
    check_output("rstwait_after_rvalid", RDATA_VALID, 0);
    check_output("rstwait_after_rdata", RDATA, 0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      r_sz   = 2'($urandom_range(0, 3));
      r_addr = $urandom();
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~(32'(size_bytes(r_sz)) - 32'd1);
      mode   = $urandom_range(0, 2);
      apply_stimulus("rand", (mode != 0), (mode != 1), r_sz, 1'($urandom_range(0, 1)),
                     r_addr, $urandom(), $urandom(), $urandom_range(1, 4));
    end

`ifdef OTTER_MEM_TIMEOUT_EN
    // A load that never sees BUS_ACK must be abandoned after 255 WAIT cycles.
    @(posedge CLK); #1;
    MEM_READ2 = 1'b1; MEM_SIZE = 2'b10; MEM_UNSIGNED = 1'b0; ADDR = 32'h0000_9000;
    BUS_ACK = 1'b0;
    wait_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (BUS_REQ !== 1'b1) break;
      wait_cnt++;
    end
    check_output("tmo_wait_cycles", wait_cnt, 255);
    check_output("tmo_err", ERR, 1);
    check_output("tmo_stall", STALL, 0);
    check_output("tmo_rvalid", RDATA_VALID, 0);
    check_output("tmo_rdata_hold", RDATA, last_rdata);
    @(posedge CLK); #1;
    drop_request();
    @(negedge CLK);
    check_output("tmo_err_clear", ERR, 0);
`else
    wait_cnt = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_mem_ctrl.md
OTTER_MEM_CTRL -- requirements
Module: otter_mem_ctrl

Interface
REQ-001 The block SHALL have these ports:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- MEM_READ2  in  1  load request from the decoder.
- MEM_WRITE  in  1  store request from the decoder.
- MEM_SIZE  in  2  ir[13:12]: 00 byte, 01 half, 10 word, 11 illegal.
- MEM_UNSIGNED  in  1  ir[14]: zero-extend loads.
- ADDR  in  32  byte address.
- WDATA  in  32  store data (rs2).
- STALL  out  1  holds the core's PC/IR.
- RDATA  out  32  extended load result.
- RDATA_VALID  out  1  one-cycle pulse when RDATA is valid.
- ERR  out  1  one-cycle misaligned or illegal-size pulse.
- BUS_REQ  out  1  bus request.
- BUS_WE  out  1  bus write enable.
- BUS_ADDR  out  32  word address, bits [1:0] = 00.
- BUS_BE  out  4  byte enables.
- BUS_WDATA  out  32  lane-replicated store data.
- BUS_ACK  in  1  bus completion; one-cycle pulse.
- BUS_RDATA  in  32  read data; valid when BUS_ACK = 1.

Function
REQ-002 The block SHALL implement an FSM with three states: IDLE, WAIT, DONE.
REQ-003 In IDLE, a request (MEM_READ2 | MEM_WRITE) SHALL be accepted if it is aligned and MEM_SIZE != 11.
- Alignment: half needs ADDR[0] = 0; word needs ADDR[1:0] = 00.
- On accept, the FSM SHALL move to WAIT and register BUS_WE, BUS_ADDR, BUS_BE and BUS_WDATA.
REQ-004 If MEM_READ2 and MEM_WRITE are both high, the write SHALL take priority.
REQ-005 A misaligned or illegal request in IDLE SHALL:
- issue no bus cycle;
- pulse ERR for one cycle;
- leave STALL = 0 and keep the FSM in IDLE.
REQ-006 STALL SHALL be combinational:
- high in IDLE during an accepted request;
- high throughout WAIT;
- low in DONE.
REQ-007 BUS_REQ SHALL be high exactly while in WAIT. All BUS_* outputs SHALL hold stable throughout WAIT.
REQ-008 When BUS_ACK = 1 in WAIT, the FSM SHALL move to DONE. For a load, it SHALL register the extended RDATA at that edge.
REQ-009 In DONE:
- RDATA_VALID SHALL be 1 for a load and 0 for a store;
- the FSM SHALL return to IDLE unconditionally;
- the request still present on the inputs SHALL NOT be re-accepted.
REQ-010 Byte lanes:
- byte: BUS_BE = 0001 << ADDR[1:0], BUS_WDATA = {4{WDATA[7:0]}};
- half: BUS_BE = 0011 << ADDR[1:0], BUS_WDATA = {2{WDATA[15:0]}};
- word: BUS_BE = 1111, BUS_WDATA = WDATA.
REQ-011 Load extraction SHALL take BUS_RDATA >> (8*ADDR[1:0]). It SHALL then sign-extend from bit 7 or 15, or zero-extend when MEM_UNSIGNED = 1. Word loads SHALL pass through unchanged.
REQ-012 Minimum latency SHALL be three cycles: accept (cycle 0), WAIT with ACK (cycle 1), DONE (cycle 2).
REQ-013 BUS_ACK outside WAIT SHALL be ignored.
REQ-014 RDATA SHALL hold its last load value until the next load completes.

Reset
REQ-015 With RST_N = 0 at a rising edge, the FSM SHALL go to IDLE and these outputs SHALL be 0:
- STALL, RDATA, RDATA_VALID, ERR;
- BUS_REQ, BUS_WE, BUS_ADDR, BUS_BE, BUS_WDATA.
REQ-016 A reset in WAIT SHALL drop BUS_REQ at that edge. A BUS_ACK arriving afterwards SHALL be ignored.

Configuration
REQ-017 When OTTER_MEM_TIMEOUT_EN is defined, an 8-bit counter SHALL behave as follows:
- it clears on entry to WAIT and increments every WAIT cycle;
- if it reaches 255 without BUS_ACK, the FSM SHALL go to DONE with RDATA_VALID = 0 and pulse ERR;
- RDATA SHALL stay unchanged.
REQ-018 When OTTER_MEM_TIMEOUT_EN is undefined, WAIT SHALL persist indefinitely until BUS_ACK, and no counter logic SHALL exist.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Byte load at ADDR = 0x1003, MEM_UNSIGNED = 0, ACK with BUS_RDATA = 0x80AA_BBCC -> BUS_BE = 1000, BUS_ADDR = 0x1000, RDATA = 0xFFFF_FF80, RDATA_VALID one cycle in DONE.
- Half store at ADDR = 0x2002, WDATA = 0x1234_ABCD -> BUS_WE = 1, BUS_BE = 1100, BUS_WDATA = 0xABCD_ABCD, STALL high for 2 cycles when ACK is immediate.
- Word load at ADDR = 0x3001 -> ERR pulse, BUS_REQ never asserted, STALL = 0.
- ACK delayed 5 cycles -> STALL high 6 cycles, bus outputs stable, single RDATA_VALID pulse.
- RST_N low in WAIT -> BUS_REQ = 0 at the next edge; a later ACK produces no RDATA_VALID.
- With OTTER_MEM_TIMEOUT_EN defined and no ACK -> ERR after 255 WAIT cycles, STALL released in DONE.
